prefix_offset_accumulator: RTL

PREFIX_OFFSET_ACCUMULATOR -- requirements
Module: prefix_offset_accumulator

---
 rtl/prefix_offset_accumulator_pkg.sv | 9 +
 rtl/prefix_offset_accumulator_mask_prefix_count.sv | 23 ++
 rtl/prefix_offset_accumulator.sv | 79 +++++++
 3 files changed

// File: rtl/prefix_offset_accumulator_pkg.sv
// prefix_offset_accumulator_pkg: shared lane-count width and lane slice helpers
package prefix_offset_accumulator_pkg;
   function automatic int cnt_width(input int p);
      return $clog2(p) + 1;
   endfunction
   function automatic int lane_lo(input int i, input int w);
      return i * w;
   endfunction
endpackage

// File: rtl/prefix_offset_accumulator_mask_prefix_count.sv
// mask_prefix_count: combinational per-lane prefix counts and popcount of a lane mask
module mask_prefix_count
   import prefix_offset_accumulator_pkg::*;
#(
   parameter int P = 8,
   parameter int EXCLUSIVE = 0,
   parameter int CW = cnt_width(P)
) (
   input  logic [P-1:0]    m,
   output logic [P*CW-1:0] pre,
   output logic [CW-1:0]   total
);
   logic [CW-1:0] acc;
   always_comb begin
      acc = '0;
      pre = '0;
      for (int i = 0; i < P; i++) begin
         pre[lane_lo(i, CW) +: CW] = (EXCLUSIVE != 0) ? acc : acc + CW'(m[i]);
         acc = acc + CW'(m[i]);
      end
      total = acc;
   end
endmodule

// File: rtl/prefix_offset_accumulator.sv
// prefix_offset_accumulator: two-stage pipeline turning lane masks into running per-lane indices
module prefix_offset_accumulator
   import prefix_offset_accumulator_pkg::*;
#(
   parameter int MAPPER_PARALLELISM = 8,
   parameter int OFFSET_WIDTH = 8,
   parameter int EXCLUSIVE = 0
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     in_valid,
   output logic                                     in_ready,
   input  logic [MAPPER_PARALLELISM-1:0]            m,
   input  logic                                     in_first,
   output logic                                     out_valid,
   input  logic                                     out_ready,
   output logic [MAPPER_PARALLELISM*OFFSET_WIDTH-1:0] c,
   output logic [cnt_width(MAPPER_PARALLELISM)-1:0] out_total,
   output logic [OFFSET_WIDTH-1:0]                  out_base,
   output logic                                     out_wrap
);
   localparam int P = MAPPER_PARALLELISM;
   localparam int W = OFFSET_WIDTH;
   localparam int CW = cnt_width(P);
   logic [P*CW-1:0] pre, s1_pre;
   logic [CW-1:0]   total, s1_total;
   logic            s1_valid, s1_first, s1_advance;
   logic [W-1:0]    offset, base;
   logic [W:0]      sum;
   logic [P*W-1:0]  c_next;
   mask_prefix_count #(.P(P), .EXCLUSIVE(EXCLUSIVE)) u_count (
      .m(m),
      .pre(pre),
      .total(total)
   );
   assign s1_advance = !out_valid || out_ready;
   assign in_ready = !rst && (!s1_valid || s1_advance);
   assign base = s1_first ? '0 : offset;
   assign sum = {1'b0, base} + (W+1)'(s1_total);
   always_comb begin
      c_next = '0;
      for (int i = 0; i < P; i++)
         c_next[lane_lo(i, W) +: W] = base + W'(s1_pre[lane_lo(i, CW) +: CW]);
   end
   // offset moves only when a beat lands in the output stage
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_first  <= 1'b0;
         s1_pre    <= '0;
         s1_total  <= '0;
         out_valid <= 1'b0;
         c         <= '0;
         out_total <= '0;
         out_base  <= '0;
         out_wrap  <= 1'b0;
         offset    <= '0;
      end else begin
         if (s1_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               c         <= c_next;
               out_total <= s1_total;
               out_base  <= base;
               out_wrap  <= sum[W];
               offset    <= sum[W-1:0];
            end
         end
         if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_first <= in_first;
               s1_pre   <= pre;
               s1_total <= total;
            end
         end
      end
   end
endmodule
